fetch_stage_buffered: RTL
=========================

# fetch_stage_buffered

Parametrised instruction-fetch stage with a DEPTH-entry in-order fetch buffer, a variable-latency instruction-memory handshake and a decode-side valid/ready stall. It sits between the redirect outputs of the execute stage (PCSourceE/PCTargetE) and the decode stage. It replaces the fixed single-register IF/ID boundary with buffering, back-pressure and flush of in-flight fetches.

## Interface
- XLEN, 32, PC/address width
- DEPTH, 4, fetch-buffer entries; power of two, ≥2 (≥3 sustains 1 instr/cycle with 1-cycle memory)
- RESET_PC, 0, PC value loaded on reset
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- PCSourceE  in  1  redirect request from execute
- PCTargetE  in  XLEN  redirect target
- imem_req  out  1  fetch request valid
- imem_addr  out  XLEN  fetch address (= PcF)
- imem_gnt  in  1  memory accepts request this cycle
- imem_rvalid  in  1  response valid; responses return in request order, ≥1 cycle after grant
- imem_rdata  in  32  fetched instruction
- ValidD  out  1  InstrD/CurrentPCD/NextPCD valid to decode
- ReadyD  in  1  decode accepts head this cycle
- InstrD  out  32  instruction at buffer head
- CurrentPCD  out  XLEN  PC of InstrD
- NextPCD  out  XLEN  CurrentPCD+4

## Operation
- State: PcF, circular buffer (per entry: pc, instr, filled), pointers alloc/fill/head, alloc_cnt, drop_cnt.
- Request: imem_req = !rst && !PCSourceE && (alloc_cnt + drop_cnt < DEPTH). Handshake = imem_req && imem_gnt: allocate entry at alloc ptr with pc=PcF, filled=0; PcF <= PcF+4.
- Response: imem_rvalid with drop_cnt>0 → discard, drop_cnt−1. Else write imem_rdata into entry at fill ptr, filled=1, fill ptr+1.
- Pop: ValidD && ReadyD → free head entry, head ptr+1, alloc_cnt−1.
- ValidD = head entry allocated && filled && !PCSourceE. When ValidD=0, InstrD, CurrentPCD and NextPCD all read 0.
- Redirect (PCSourceE=1): PcF <= PCTargetE; all entries invalidated; pointers and alloc_cnt cleared; no request or pop this cycle. drop_cnt <= (old drop_cnt + allocated-unfilled entries) − (imem_rvalid ? 1 : 0), so every outstanding response is discarded exactly once.
- Simultaneous alloc/pop: alloc_cnt unchanged. Simultaneous response/redirect: the response is counted in the drop arithmetic above and not written.
- Arithmetic: PC +4 modulo 2^XLEN (all-ones−3 wraps to 0). Counters are $clog2(DEPTH+1) bits. Pointers wrap modulo DEPTH.
- Full (alloc_cnt+drop_cnt = DEPTH): imem_req low. Empty: ValidD low.

## Timing
- Reset (async assert, sync release): PcF=RESET_PC, counters and pointers 0, all filled=0. Outputs: imem_req=0, imem_addr=RESET_PC, ValidD=0, InstrD=0, CurrentPCD=0, NextPCD=0.
- Reset mid-operation: all in-flight state is lost. Responses arriving after release are not dropped; the memory is reset with this block.
- Latency: grant in cycle t, rvalid in cycle t+k (k≥1), ValidD from cycle t+k+1.
- ReadyD=0: head outputs are held stable; requests continue until full.
- Redirect in cycle t: imem_addr=PCTargetE from t+1; the first new instruction is visible no earlier than t+3.

## Structure
- Shared package fetch_pkg holds: INSTR_W=32, PC_INC=4, default XLEN, the fetch-buffer entry struct (pc, instr, filled).
- Sub-module fetch_buffer: DEPTH-entry circular buffer with alloc/fill/pop/flush ports and counts. The top level holds PcF, drop_cnt and the request logic.

## Test plan
- Reset with RESET_PC=0x100, gnt=1, 1-cycle memory, ReadyD=1 → imem_addr 0x100, 0x104, 0x108…; ValidD first high 2 cycles after the first grant, then 1/cycle; CurrentPCD 0x100 paired with NextPCD 0x104.
- ReadyD=0 for 10 cycles, DEPTH=4 → exactly 4 grants, then imem_req=0; head (0x100) held stable; ReadyD=1 resumes in-order delivery.
- Memory latency 3, 3 requests outstanding, PCSourceE=1 with target 0x200 → 3 late responses discarded; next ValidD shows CurrentPCD=0x200.
- Redirect coincident with imem_rvalid and with ReadyD=1 → response dropped, no pop, ValidD=0 that cycle, drop_cnt equals remaining outstanding.
- PcF=0xFFFFFFFC fetch → next imem_addr=0x0; NextPCD=0x0.
- Assert rst mid-stream → ValidD, InstrD, CurrentPCD and NextPCD are 0 immediately (async); after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared widths and the fetch-buffer entry record for the buffered fetch stage.
package fetch_pkg;
  localparam int XLEN_DEF = 32;
  localparam int INSTR_W  = 32;
  localparam int PC_INC   = 4;

  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [INSTR_W-1:0]  instr;
    logic                filled;
  } fetchEntry_t;
endpackage

// File: rtl/fetch_buffer.sv
// In-order circular fetch buffer: slot allocated at grant, filled by response, popped at head.
// Head view is combinational (0 cycles); flush clears all slots, pointers and counts in one cycle.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                allocEn,
  input  logic [XLEN_DEF-1:0] allocPc,
  input  logic                fillEn,
  input  logic [INSTR_W-1:0]  fillInstr,
  input  logic                popEn,
  output logic                headVld,
  output logic [XLEN_DEF-1:0] headPc,
  output logic [INSTR_W-1:0]  headInstr,
  output logic [CW-1:0]       allocCnt,
  output logic [CW-1:0]       unfilledCnt
);
  localparam int PW = $clog2(DEPTH);

  fetchEntry_t   entries [DEPTH];
  fetchEntry_t   head;
  logic [PW-1:0] allocPtr;
  logic [PW-1:0] fillPtr;
  logic [PW-1:0] headPtr;

  assign head      = entries[headPtr];
  assign headVld   = (allocCnt != '0) && head.filled;
  assign headPc    = head.pc;
  assign headInstr = head.instr;

  // Responses fill strictly in grant order, so fillPtr trails allocPtr by unfilledCnt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
      allocPtr    <= '0;
      fillPtr     <= '0;
      headPtr     <= '0;
      allocCnt    <= '0;
      unfilledCnt <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) entries[i].filled <= 1'b0;
      allocPtr    <= '0;
      fillPtr     <= '0;
      headPtr     <= '0;
      allocCnt    <= '0;
      unfilledCnt <= '0;
    end else begin
      if (allocEn) begin
        entries[allocPtr] <= '{pc: allocPc, instr: '0, filled: 1'b0};
        allocPtr          <= allocPtr + PW'(1);
      end
      if (fillEn) begin
        entries[fillPtr].instr  <= fillInstr;
        entries[fillPtr].filled <= 1'b1;
        fillPtr                 <= fillPtr + PW'(1);
      end
      if (popEn) begin
        entries[headPtr].filled <= 1'b0;
        headPtr                 <= headPtr + PW'(1);
      end
      allocCnt    <= allocCnt + CW'(allocEn) - CW'(popEn);
      unfilledCnt <= unfilledCnt + CW'(allocEn) - CW'(fillEn);
    end
  end
endmodule

// File: rtl/fetch_stage_buffered.sv
// Fetch stage: PC, imem request/drop logic and a DEPTH-entry buffer; ValidD 1 cycle after response.
// Requests stop when buffer plus pending drops reach DEPTH; ReadyD low holds the head stable.
module fetch_stage_buffered
  import fetch_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEF,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               PCSourceE,
  input  logic [XLEN-1:0]    PCTargetE,
  output logic               imem_req,
  output logic [XLEN-1:0]    imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               ValidD,
  input  logic               ReadyD,
  output logic [INSTR_W-1:0] InstrD,
  output logic [XLEN-1:0]    CurrentPCD,
  output logic [XLEN-1:0]    NextPCD
);
  localparam int            CW      = $clog2(DEPTH + 1);
  localparam logic [CW:0]   DEPTH_C = (CW + 1)'(DEPTH);

  logic [XLEN-1:0]    PcF;
  logic [CW-1:0]      dropCnt;
  logic [CW-1:0]      allocCnt;
  logic [CW-1:0]      unfilledCnt;
  logic [CW:0]        inFlight;
  logic               allocEn;
  logic               fillEn;
  logic               dropEn;
  logic               popEn;
  logic               headVld;
  logic [XLEN-1:0]    headPc;
  logic [INSTR_W-1:0] headInstr;

  // Slots still owed a discarded response count against capacity too.
  assign inFlight  = {1'b0, allocCnt} + {1'b0, dropCnt};
  assign imem_req  = !rst && !PCSourceE && (inFlight < DEPTH_C);
  assign imem_addr = PcF;
  assign allocEn   = imem_req && imem_gnt;
  assign dropEn    = imem_rvalid && (dropCnt != '0);
  assign fillEn    = imem_rvalid && (dropCnt == '0) && !PCSourceE;
  assign ValidD    = headVld && !PCSourceE;
  assign popEn     = ValidD && ReadyD;

  assign InstrD     = ValidD ? headInstr : '0;
  assign CurrentPCD = ValidD ? headPc : '0;
  assign NextPCD    = ValidD ? headPc + XLEN'(PC_INC) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      PcF     <= RESET_PC;
      dropCnt <= '0;
    end else if (PCSourceE) begin
      // Every response still owed to a flushed slot must be discarded exactly once.
      PcF     <= PCTargetE;
      dropCnt <= dropCnt + unfilledCnt - CW'(imem_rvalid);
    end else begin
      if (allocEn) PcF <= PcF + XLEN'(PC_INC);
      if (dropEn) dropCnt <= dropCnt - CW'(1);
    end
  end

  fetch_buffer #(
    .DEPTH(DEPTH),
    .CW   (CW)
  ) u_buf (
    .clk        (clk),
    .rst        (rst),
    .flush      (PCSourceE),
    .allocEn    (allocEn),
    .allocPc    (PcF),
    .fillEn     (fillEn),
    .fillInstr  (imem_rdata),
    .popEn      (popEn),
    .headVld    (headVld),
    .headPc     (headPc),
    .headInstr  (headInstr),
    .allocCnt   (allocCnt),
    .unfilledCnt(unfilledCnt)
  );
endmodule
